// File: rtl/messbauer_discr_pkg.sv
// Shared FSM encoding, parameter-legality rules and quota arithmetic for the
// Mossbauer differential discriminator generator.
package messbauer_discr_pkg;

    localparam logic [2:0] ST_IDLE           = 3'd0;
    localparam logic [2:0] ST_LOWER_HIGH     = 3'd1;
    localparam logic [2:0] ST_UPPER_HIGH     = 3'd2;
    localparam logic [2:0] ST_UPPER_LOW      = 3'd3;
    localparam logic [2:0] ST_LOWER_LOW_WAIT = 3'd4;
    localparam logic [2:0] ST_PAUSE          = 3'd5;
    localparam logic [2:0] ST_DONE           = 3'd6;

    localparam int MIN_LOWER_UPPER_GAP = 2;
    localparam int MIN_UPPER_DURATION  = 1;
    localparam int MIN_IMPULSES        = 1;
    localparam int MIN_PAUSE           = 0;

    function automatic logic params_legal(input int l, input int u, input int p,
                                          input int n, input int s);
        return (l >= u + MIN_LOWER_UPPER_GAP) && (u >= MIN_UPPER_DURATION) &&
               (s >= 0) && (s <= n) && (n >= MIN_IMPULSES) && (p >= MIN_PAUSE);
    endfunction

    // Quota is clamped to the burst length so late channels reject nothing.
    function automatic logic [31:0] calc_quota(input logic [31:0] base, input logic [31:0] index,
                                               input logic [31:0] step, input logic [31:0] limit);
        logic [31:0] q;
        q = base + index * step;
        return (q > limit) ? limit : q;
    endfunction

endpackage

// File: rtl/messbauer_discr_pulse_shaper.sv
// Generates one discriminator impulse: lower_threshold for LOWER_DURATION cycles and,
// for a rejected impulse, upper_threshold nested inside it starting one cycle late.
module messbauer_discr_pulse_shaper #(
    parameter int LOWER_DURATION = 3,
    parameter int UPPER_DURATION = 1
) (
    input  logic aclk,
    input  logic areset,
    input  logic start,
    input  logic reject,
    output logic lower,
    output logic upper,
    output logic upper_end,
    output logic finished
);
    localparam logic [31:0] CNT_LOAD   = 32'(LOWER_DURATION - 1);
    localparam logic [31:0] UPPER_LAST = 32'(LOWER_DURATION - 1 - UPPER_DURATION);

    logic        lower_q, lower_d;
    logic        upper_q, upper_d;
    logic        reject_q, reject_d;
    logic [31:0] cnt_q, cnt_d;

    assign finished  = lower_q && (cnt_q == '0);
    assign upper_end = upper_q && (cnt_q == UPPER_LAST);
    assign lower     = lower_q;
    assign upper     = upper_q;

    always_comb begin
        lower_d  = lower_q;
        upper_d  = upper_q;
        reject_d = reject_q;
        cnt_d    = cnt_q;
        if (lower_q) begin
            if (cnt_q != '0) cnt_d = cnt_q - 32'd1;
            else             lower_d = 1'b0;
            if (reject_q && (cnt_q == CNT_LOAD)) upper_d = 1'b1;
            if (upper_end)                       upper_d = 1'b0;
        end
        // A restart on the final high cycle lets zero-pause bursts run back to back.
        if (start && (!lower_q || finished)) begin
            lower_d  = 1'b1;
            upper_d  = 1'b0;
            reject_d = reject;
            cnt_d    = CNT_LOAD;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lower_q  <= 1'b0;
            upper_q  <= 1'b0;
            reject_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            lower_q  <= lower_d;
            upper_q  <= upper_d;
            reject_q <= reject_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/messbauer_diff_discriminator_gen.sv
// Burst sequencer for the Mossbauer differential discriminator: N impulses per velocity
// channel, first Q selected. Define MESSBAUER_DISCR_STATS_EN to add impulse totals.
//
// state          | meaning
// IDLE           | waiting for an enabled channel_strobe
// LOWER_HIGH     | lower_threshold high, upper not (yet) raised
// UPPER_HIGH     | rejected impulse, upper_threshold high
// UPPER_LOW      | upper fallen, lower still high
// LOWER_LOW_WAIT | last gap cycle, next impulse launched
// PAUSE          | both outputs low between impulses
// DONE           | channel_done pulse, burst closing
module messbauer_diff_discriminator_gen #(
    parameter int LOWER_THRESHOLD_DURATION     = 3,
    parameter int UPPER_THRESHOLD_DURATION     = 1,
    parameter int DISCRIMINATOR_IMPULSES_PAUSE = 10,
    parameter int IMPULSES_PER_CHANNEL         = 16,
    parameter int IMPULSES_FOR_SELECTION       = 4,
    parameter int SELECTION_STEP               = 0,
    parameter int CHANNELS                     = 4096,
    localparam int CHANNEL_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     enable,
    input  logic                     channel_strobe,
    output logic                     lower_threshold,
    output logic                     upper_threshold,
    output logic [CHANNEL_WIDTH-1:0] channel_index,
    output logic                     busy,
    output logic                     channel_done,
    output logic                     strobe_overrun
`ifdef MESSBAUER_DISCR_STATS_EN
    ,
    output logic [15:0]              selected_total,
    output logic [15:0]              rejected_total
`endif
);
    import messbauer_discr_pkg::*;

    localparam int P = DISCRIMINATOR_IMPULSES_PAUSE;
    localparam logic [31:0] LAST_IMPULSE = 32'(IMPULSES_PER_CHANNEL - 1);
    localparam logic [31:0] PAUSE_LOAD   = (P >= 2) ? 32'(P - 2) : 32'd0;
    localparam logic [CHANNEL_WIDTH-1:0] LAST_CHANNEL = CHANNEL_WIDTH'(CHANNELS - 1);

    if (!params_legal(LOWER_THRESHOLD_DURATION, UPPER_THRESHOLD_DURATION, P,
                      IMPULSES_PER_CHANNEL, IMPULSES_FOR_SELECTION)) begin : g_illegal
        $error("messbauer_diff_discriminator_gen: illegal parameter combination");
    end

    logic [2:0]               state_q, state_d;
    logic [31:0]              imp_q, imp_d;
    logic [31:0]              pause_q, pause_d;
    logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     overrun_q, overrun_d;
    logic                     start, start_reject, advance;
    logic                     sh_upper_end, sh_finished;
    logic [31:0]              quota, next_imp;
    logic                     cur_reject;

    assign quota      = calc_quota(32'(IMPULSES_FOR_SELECTION), 32'(chan_q),
                                   32'(SELECTION_STEP), 32'(IMPULSES_PER_CHANNEL));
    assign next_imp   = imp_q + 32'd1;
    assign cur_reject = (imp_q >= quota);

    always_comb begin
        state_d      = state_q;
        imp_d        = imp_q;
        pause_d      = pause_q;
        chan_d       = chan_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        overrun_d    = channel_strobe && (state_q != ST_IDLE);
        start        = 1'b0;
        start_reject = cur_reject;
        advance      = 1'b0;
        case (state_q)
            ST_IDLE: if (enable && channel_strobe) begin
                start        = 1'b1;
                start_reject = (quota == '0);
                imp_d        = '0;
                busy_d       = 1'b1;
                state_d      = ST_LOWER_HIGH;
            end
            ST_LOWER_HIGH: begin
                if (sh_finished)     advance = 1'b1;
                else if (cur_reject) state_d = ST_UPPER_HIGH;
            end
            ST_UPPER_HIGH: if (sh_upper_end) state_d = ST_UPPER_LOW;
            ST_UPPER_LOW:  if (sh_finished) advance = 1'b1;
            ST_PAUSE: begin
                if (pause_q == '0) state_d = ST_LOWER_LOW_WAIT;
                else               pause_d = pause_q - 32'd1;
            end
            ST_LOWER_LOW_WAIT: begin
                start   = 1'b1;
                state_d = ST_LOWER_HIGH;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (advance) begin
            if (imp_q == LAST_IMPULSE) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                chan_d  = (chan_q == LAST_CHANNEL) ? '0 : chan_q + 1'b1;
            end else begin
                imp_d = next_imp;
                if (P == 0) begin
                    start        = 1'b1;
                    start_reject = (next_imp >= quota);
                    state_d      = ST_LOWER_HIGH;
                end else if (P == 1) begin
                    state_d = ST_LOWER_LOW_WAIT;
                end else begin
                    state_d = ST_PAUSE;
                    pause_d = PAUSE_LOAD;
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            imp_q     <= '0;
            pause_q   <= '0;
            chan_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            imp_q     <= imp_d;
            pause_q   <= pause_d;
            chan_q    <= chan_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    messbauer_discr_pulse_shaper #(
        .LOWER_DURATION (LOWER_THRESHOLD_DURATION),
        .UPPER_DURATION (UPPER_THRESHOLD_DURATION)
    ) u_shaper (
        .aclk      (aclk),
        .areset    (areset),
        .start     (start),
        .reject    (start_reject),
        .lower     (lower_threshold),
        .upper     (upper_threshold),
        .upper_end (sh_upper_end),
        .finished  (sh_finished)
    );

    assign channel_index  = chan_q;
    assign busy           = busy_q;
    assign channel_done   = done_q;
    assign strobe_overrun = overrun_q;

`ifdef MESSBAUER_DISCR_STATS_EN
    logic [15:0] sel_tot_q, sel_tot_d, rej_tot_q, rej_tot_d;

    always_comb begin
        sel_tot_d = sel_tot_q;
        rej_tot_d = rej_tot_q;
        if (sh_finished) begin
            if (cur_reject) begin
                if (rej_tot_q != 16'hFFFF) rej_tot_d = rej_tot_q + 16'd1;
            end else begin
                if (sel_tot_q != 16'hFFFF) sel_tot_d = sel_tot_q + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sel_tot_q <= '0;
            rej_tot_q <= '0;
        end else begin
            sel_tot_q <= sel_tot_d;
            rej_tot_q <= rej_tot_d;
        end
    end

    assign selected_total = sel_tot_q;
    assign rejected_total = rej_tot_q;
`endif

endmodule

// File: tb/tb_messbauer_diff_discriminator_gen.sv
// Bench: DUT 0 uses default parameters, DUT 1 uses SELECTION_STEP=5 and CHANNELS=4;
// both share inputs and run in lockstep. A negedge monitor measures every impulse.
module tb_messbauer_diff_discriminator_gen;
    localparam int L = 3;
    localparam int U = 1;
    localparam int P = 10;
    localparam int N = 16;

    typedef struct {
        int sel;
        int idx;
    } exp_t;

    typedef struct {
        int sel_a;
        int idx_a;
        int sel_b;
        int idx_b;
        bit drop_en;
        bit mid_strobe;
        bit done_strobe;
    } vec_t;

    logic        aclk, areset, enable, channel_strobe;
    logic        lower_a, upper_a, busy_a, done_a, ovr_a;
    logic        lower_b, upper_b, busy_b, done_b, ovr_b;
    logic [11:0] idx_a;
    logic [1:0]  idx_b;
`ifdef MESSBAUER_DISCR_STATS_EN
    logic [15:0] sel_tot_a, rej_tot_a, sel_tot_b, rej_tot_b;
`endif

    messbauer_diff_discriminator_gen dut_a (
        .aclk(aclk), .areset(areset), .enable(enable), .channel_strobe(channel_strobe),
        .lower_threshold(lower_a), .upper_threshold(upper_a), .channel_index(idx_a),
        .busy(busy_a), .channel_done(done_a), .strobe_overrun(ovr_a)
`ifdef MESSBAUER_DISCR_STATS_EN
        , .selected_total(sel_tot_a), .rejected_total(rej_tot_a)
`endif
    );

    messbauer_diff_discriminator_gen #(.SELECTION_STEP(5), .CHANNELS(4)) dut_b (
        .aclk(aclk), .areset(areset), .enable(enable), .channel_strobe(channel_strobe),
        .lower_threshold(lower_b), .upper_threshold(upper_b), .channel_index(idx_b),
        .busy(busy_b), .channel_done(done_b), .strobe_overrun(ovr_b)
`ifdef MESSBAUER_DISCR_STATS_EN
        , .selected_total(sel_tot_b), .rejected_total(rej_tot_b)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    logic lo[2], up[2], dn[2], ov[2];
    int   idx[2];
    assign lo[0] = lower_a;  assign lo[1] = lower_b;
    assign up[0] = upper_a;  assign up[1] = upper_b;
    assign dn[0] = done_a;   assign dn[1] = done_b;
    assign ov[0] = ovr_a;    assign ov[1] = ovr_b;
    assign idx[0] = int'(idx_a);
    assign idx[1] = int'(idx_b);

    task automatic check(input string name, input int dut, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d", name, dut, act, exp);
        end
    endtask

    bit prev_lo[2], prev_up[2], had_up[2];
    int hi_len[2], gap[2], up_len[2], up_at[2], imps[2], sel[2];
    int n_done[2] = '{0, 0};
    int n_ov[2] = '{0, 0};

    always @(negedge aclk) begin
        for (int d = 0; d < 2; d++) begin
            if (areset) begin
                prev_lo[d] = 0; prev_up[d] = 0; had_up[d] = 0;
                hi_len[d] = 0; gap[d] = 0; up_len[d] = 0; up_at[d] = 0;
                imps[d] = 0; sel[d] = 0;
            end else begin
                automatic bit   have;
                automatic exp_t e;
                have = (d == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
                if (have) e = (d == 0) ? q_a[0] : q_b[0];
                if (ov[d]) n_ov[d]++;
                if (lo[d] && !prev_lo[d]) begin
                    if (imps[d] > 0) check("gap_len", d, gap[d], P);
                    hi_len[d] = 1;
                    had_up[d] = 0;
                end else if (lo[d]) begin
                    hi_len[d]++;
                end
                if (up[d]) check("upper_inside_lower", d, int'(lo[d]), 1);
                if (up[d] && !prev_up[d]) begin
                    up_at[d] = hi_len[d]; up_len[d] = 1; had_up[d] = 1;
                end else if (up[d]) begin
                    up_len[d]++;
                end
                if (prev_lo[d] && !lo[d]) begin
                    check("lower_len", d, hi_len[d], L);
                    if (have) check("impulse_rejected", d, int'(had_up[d]), int'(imps[d] >= e.sel));
                    if (had_up[d]) begin
                        check("upper_delay", d, up_at[d], 2);
                        check("upper_len", d, up_len[d], U);
                    end else begin
                        sel[d]++;
                    end
                    imps[d]++;
                    gap[d] = 1;
                end else if (!lo[d]) begin
                    gap[d]++;
                end
                if (dn[d]) begin
                    check("done_after_last", d, gap[d], 1);
                    check("expectation_queued", d, int'(have), 1);
                    if (have) begin
                        if (d == 0) void'(q_a.pop_front());
                        else        void'(q_b.pop_front());
                        check("impulses", d, imps[d], N);
                        check("selected", d, sel[d], e.sel);
                        check("channel_index", d, idx[d], e.idx);
                    end
                    n_done[d]++;
                    imps[d] = 0;
                    sel[d] = 0;
                end
                prev_lo[d] = lo[d];
                prev_up[d] = up[d];
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge aclk);
        #1;
    endtask

    task automatic pulse_strobe();
        channel_strobe = 1'b1;
        idle_cycles(1);
        channel_strobe = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while ((n_done[0] < target || n_done[1] < target) && t < 1000) begin
            idle_cycles(1);
            t++;
        end
        check("burst_completed", 0, int'(n_done[0] >= target && n_done[1] >= target), 1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_lower"}, 0, int'(lower_a), 0);
        check({tag, "_upper"}, 0, int'(upper_a), 0);
        check({tag, "_busy"}, 0, int'(busy_a), 0);
        check({tag, "_index"}, 0, int'(idx_a), 0);
        check({tag, "_done"}, 0, int'(done_a), 0);
        check({tag, "_lower"}, 1, int'(lower_b), 0);
        check({tag, "_upper"}, 1, int'(upper_b), 0);
        check({tag, "_busy"}, 1, int'(busy_b), 0);
        check({tag, "_index"}, 1, int'(idx_b), 0);
    endtask

    vec_t vecs[5];

    initial begin
        int target, ups, t;
        bit prevu;
        vecs[0] = '{4, 1,  4, 1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4, 2,  9, 2, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4, 3, 14, 3, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{4, 4, 16, 0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4, 5,  4, 1, 1'b0, 1'b0, 1'b0};
        target = 0;

        areset = 1'b1; enable = 1'b0; channel_strobe = 1'b0;
        #1;
        check_cleared("reset");
        idle_cycles(3);
        areset = 1'b0;
        idle_cycles(2);

        // Strobe with enable low is ignored without an overrun.
        pulse_strobe();
        idle_cycles(5);
        check("disabled_busy", 0, int'(busy_a), 0);
        check("disabled_overrun", 0, n_ov[0] + n_ov[1], 0);

        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            q_a.push_back('{vecs[i].sel_a, vecs[i].idx_a});
            q_b.push_back('{vecs[i].sel_b, vecs[i].idx_b});
            pulse_strobe();
            check("first_lower", 0, int'(lower_a), 1);
            check("busy_rise", 1, int'(busy_b), 1);
            if (vecs[i].drop_en) enable = 1'b0;
            if (vecs[i].mid_strobe) begin
                idle_cycles(50);
                pulse_strobe();
            end
            if (vecs[i].done_strobe) begin
                t = 0;
                while (!done_a && t < 400) begin
                    idle_cycles(1);
                    t++;
                end
                check("done_for_strobe", 0, int'(done_a), 1);
                pulse_strobe();
            end
            target++;
            wait_done(target);
            enable = 1'b1;
            idle_cycles(1);
            check("busy_after_done", 0, int'(busy_a), 0);
`ifdef MESSBAUER_DISCR_STATS_EN
            if (i == 2) begin
                check("selected_total", 0, int'(sel_tot_a), 12);
                check("rejected_total", 0, int'(rej_tot_a), 36);
            end
`endif
        end
        check("overrun_count", 0, n_ov[0], 2);
        check("overrun_count", 1, n_ov[1], 2);

        // Reset while DUT 0's third upper pulse is high, with no clock edge in between.
        pulse_strobe();
        ups = 0; prevu = 1'b0; t = 0;
        while (ups < 3 && t < 300) begin
            idle_cycles(1);
            if (upper_a && !prevu) ups++;
            prevu = upper_a;
            t++;
        end
        check("third_upper_seen", 0, ups, 3);
        check("upper_before_reset", 0, int'(upper_a), 1);
        #2 areset = 1'b1;
        #1;
        check_cleared("async_reset");
`ifdef MESSBAUER_DISCR_STATS_EN
        check("selected_total_reset", 0, int'(sel_tot_a), 0);
        check("rejected_total_reset", 0, int'(rej_tot_a), 0);
`endif
        idle_cycles(2);
        areset = 1'b0;
        idle_cycles(2);
        q_a.push_back('{4, 1});
        q_b.push_back('{4, 1});
        pulse_strobe();
        target = n_done[0] + 1;
        wait_done(target);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
